score_keeper: RTL

Sits directly downstream of the ball position logic and upstream of VGAController. It watches ball_x each game tick and detects when the ball crosses a goal line. On a crossing it credits a point to the correct player and keeps each player's score as two BCD digits. It also runs a play/hold/game-over FSM that drives the score digit inputs of VGAController.

---
 rtl/score_keeper.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/score_keeper.sv
// score_keeper
// Watches the ball x position every game tick, detects goal-line crossings,
// keeps each player's score as two BCD digits and runs the PLAY/HOLD/OVER
// game FSM whose digit outputs feed the VGA controller.
//
// Ports:
//   clk               game clock, all state changes on rising edge
//   reset             asynchronous, active-low; clears all state
//   ball_x            ball upper-left x coordinate (pixels)
//   ball_width        ball width (pixels)
//   wall_width        goal-line inset from each screen edge (pixels)
//   new_game          clears the scores, honoured only in OVER
//   score_*_tens/ones BCD score digits per player (registered)
//   point_left/right  one-cycle pulse when that player scores
//   game_over         high while in OVER
//   winner            1 = left won, 0 = right won (valid with game_over)
module score_keeper #(
    parameter int SCREEN_W  = 640,
    parameter int WIN_SCORE = 11
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] ball_x,
    input  logic [5:0] ball_width,
    input  logic [5:0] wall_width,
    input  logic       new_game,
    output logic [3:0] score_left_tens,
    output logic [3:0] score_left_ones,
    output logic [3:0] score_right_tens,
    output logic [3:0] score_right_ones,
    output logic       point_left,
    output logic       point_right,
    output logic       game_over,
    output logic       winner
);

    typedef enum logic [1:0] {
        ST_PLAY = 2'd0,
        ST_HOLD = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    localparam logic [11:0] SCREEN_W_C  = 12'(SCREEN_W);
    localparam logic [6:0]  WIN_SCORE_C = 7'(WIN_SCORE);

    // Two-digit BCD increment that saturates at 99 instead of wrapping.
    function automatic logic [7:0] bcd_inc(input logic [7:0] bcd);
        logic [7:0] res;
        res = bcd;
        if (bcd == 8'h99) begin
            res = bcd;
        end else if (bcd[3:0] == 4'd9) begin
            res = {bcd[7:4] + 4'd1, 4'd0};
        end else begin
            res = {bcd[7:4], bcd[3:0] + 4'd1};
        end
        return res;
    endfunction

    // Binary value of a two-digit BCD score (0..99).
    function automatic logic [6:0] bcd_value(input logic [7:0] bcd);
        return 7'({3'd0, bcd[7:4]} * 7'd10) + {3'd0, bcd[3:0]};
    endfunction

    state_t     state_r;
    state_t     state_nxt_s;
    logic [7:0] left_bcd_r;
    logic [7:0] right_bcd_r;
    logic [7:0] left_nxt_s;
    logic [7:0] right_nxt_s;
    logic [7:0] left_inc_s;
    logic [7:0] right_inc_s;
    logic       left_win_s;
    logic       right_win_s;
    logic       point_left_r;
    logic       point_right_r;
    logic       point_left_nxt_s;
    logic       point_right_nxt_s;
    logic       game_over_r;
    logic       winner_r;
    logic       winner_nxt_s;
    logic [11:0] right_edge_s;
    logic       goal_l_s;
    logic       goal_r_s;
    logic       only_l_s;
    logic       only_r_s;

    // Goal detection. The left-goal test is rearranged as
    // ball_x + ball_width + wall_width > SCREEN_W so that nothing can underflow.
    always_comb begin
        right_edge_s = {2'd0, ball_x} + {6'd0, ball_width} + {6'd0, wall_width};
        goal_l_s     = (right_edge_s > SCREEN_W_C);
        goal_r_s     = ({2'd0, ball_x} < {6'd0, wall_width});
        only_l_s     = goal_l_s & ~goal_r_s;
        only_r_s     = goal_r_s & ~goal_l_s;
        left_inc_s   = bcd_inc(left_bcd_r);
        right_inc_s  = bcd_inc(right_bcd_r);
        left_win_s   = (bcd_value(left_inc_s) == WIN_SCORE_C);
        right_win_s  = (bcd_value(right_inc_s) == WIN_SCORE_C);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_HOLD;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic. HOLD waits for a fully clear cycle so one
    // crossing earns exactly one point.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_PLAY: begin
                if (only_l_s) begin
                    state_nxt_s = left_win_s ? ST_OVER : ST_HOLD;
                end else if (only_r_s) begin
                    state_nxt_s = right_win_s ? ST_OVER : ST_HOLD;
                end else begin
                    state_nxt_s = ST_PLAY;
                end
            end
            ST_HOLD: begin
                if (!goal_l_s && !goal_r_s) begin
                    state_nxt_s = ST_PLAY;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            ST_OVER: begin
                if (new_game) begin
                    state_nxt_s = ST_HOLD;
                end else begin
                    state_nxt_s = ST_OVER;
                end
            end
            default: state_nxt_s = ST_HOLD;
        endcase
    end

    // FSM output logic: next values for the scores, pulses and winner flag.
    always_comb begin
        left_nxt_s        = left_bcd_r;
        right_nxt_s       = right_bcd_r;
        point_left_nxt_s  = 1'b0;
        point_right_nxt_s = 1'b0;
        winner_nxt_s      = winner_r;
        case (state_r)
            ST_PLAY: begin
                if (only_l_s) begin
                    left_nxt_s       = left_inc_s;
                    point_left_nxt_s = 1'b1;
                    if (left_win_s) begin
                        winner_nxt_s = 1'b1;
                    end else begin
                        winner_nxt_s = winner_r;
                    end
                end else if (only_r_s) begin
                    right_nxt_s       = right_inc_s;
                    point_right_nxt_s = 1'b1;
                    if (right_win_s) begin
                        winner_nxt_s = 1'b0;
                    end else begin
                        winner_nxt_s = winner_r;
                    end
                end else begin
                    left_nxt_s = left_bcd_r;
                end
            end
            ST_OVER: begin
                if (new_game) begin
                    left_nxt_s  = 8'd0;
                    right_nxt_s = 8'd0;
                end else begin
                    left_nxt_s = left_bcd_r;
                end
            end
            default: begin
                left_nxt_s = left_bcd_r;
            end
        endcase
    end

    // Output registers; game_over tracks the registered FSM state exactly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            left_bcd_r    <= 8'd0;
            right_bcd_r   <= 8'd0;
            point_left_r  <= 1'b0;
            point_right_r <= 1'b0;
            game_over_r   <= 1'b0;
            winner_r      <= 1'b0;
        end else begin
            left_bcd_r    <= left_nxt_s;
            right_bcd_r   <= right_nxt_s;
            point_left_r  <= point_left_nxt_s;
            point_right_r <= point_right_nxt_s;
            game_over_r   <= (state_nxt_s == ST_OVER);
            winner_r      <= winner_nxt_s;
        end
    end

    assign score_left_tens  = left_bcd_r[7:4];
    assign score_left_ones  = left_bcd_r[3:0];
    assign score_right_tens = right_bcd_r[7:4];
    assign score_right_ones = right_bcd_r[3:0];
    assign point_left       = point_left_r;
    assign point_right      = point_right_r;
    assign game_over        = game_over_r;
    assign winner           = winner_r;

endmodule
